// File: rtl/operand_pkg.sv
// Shared constants and helpers for the operand entry front-end that feeds
// the AdderLEDs block.
package operand_pkg;

  localparam int OPW                = 2;
  localparam int DEB_CYCLES_DEFAULT = 100000;

  // Operand step: wraps naturally at 2^OPW (3 -> 0 for the 2-bit adder).
  function automatic logic [OPW-1:0] sat_wrap_inc(input logic [OPW-1:0] v);
    return v + {{(OPW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-flop synchroniser, stability counter and a
// single-cycle rising-edge press pulse on the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic             stable_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0     <= 1'b0;
      sync_p1     <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      cnt         <= '0;
    end else begin
      sync_p0     <= btn_raw;
      sync_p1     <= sync_p0;
      stable_prev <= stable;
      // Any sample agreeing with the stable level restarts the stability window.
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign level = stable;
  assign press = stable & ~stable_prev;

endmodule

// File: rtl/operand_entry.sv
// Turns three bouncy board buttons into the two registered 2-bit operands
// for the adder, plus a one-cycle pulse whenever either operand changes.
module operand_entry
  import operand_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btn_inc1,
  input  logic           btn_inc2,
  input  logic           btn_clear,
  output logic [OPW-1:0] sayi1,
  output logic [OPW-1:0] sayi2,
  output logic           degisti
);

  logic inc1_lvl, inc1_press;
  logic inc2_lvl, inc2_press;
  logic clr_lvl,  clr_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_inc1),
    .level   (inc1_lvl),
    .press   (inc1_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_inc2),
    .level   (inc2_lvl),
    .press   (inc2_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clear),
    .level   (clr_lvl),
    .press   (clr_press)
  );

  logic           inc1_ev, inc2_ev, clr_ev;
  logic [OPW-1:0] sayi1_nxt, sayi2_nxt;
  logic           degisti_nxt;

  assign inc1_ev = inc1_press & inc1_lvl;
  assign inc2_ev = inc2_press & inc2_lvl;
  assign clr_ev  = clr_press  & clr_lvl;

  // Clear wins over any increment arriving in the same cycle.
  always_comb begin
    sayi1_nxt = sayi1;
    sayi2_nxt = sayi2;
    if (clr_ev) begin
      sayi1_nxt = '0;
      sayi2_nxt = '0;
    end else begin
      if (inc1_ev) sayi1_nxt = sat_wrap_inc(sayi1);
      if (inc2_ev) sayi2_nxt = sat_wrap_inc(sayi2);
    end
    degisti_nxt = (sayi1_nxt != sayi1) || (sayi2_nxt != sayi2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sayi1   <= '0;
      sayi2   <= '0;
      degisti <= 1'b0;
    end else begin
      sayi1   <= sayi1_nxt;
      sayi2   <= sayi2_nxt;
      degisti <= degisti_nxt;
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with DEB_CYCLES = 4: table of button
// presses with expected operands, plus latency, bounce and reset sequences.
module tb_operand_entry;
  import operand_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           b1 = 1'b0;
  logic           b2 = 1'b0;
  logic           bc = 1'b0;
  logic [OPW-1:0] s1;
  logic [OPW-1:0] s2;
  logic           deg;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  operand_entry #(.DEB_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_inc1  (b1),
    .btn_inc2  (b2),
    .btn_clear (bc),
    .sayi1     (s1),
    .sayi2     (s2),
    .degisti   (deg)
  );

  typedef struct {
    string nm;
    bit    i1;
    bit    i2;
    bit    c;
    int    e1;
    int    e2;
    int    ep;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Advance n rising edges; sample 1 time unit after each and count degisti.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (deg) pulses++;
    end
  endtask

  // Edge-by-edge check that sayi1 steps 0 -> 1 on edge 6 with a single pulse.
  task automatic latency_check(input string tag);
    for (int e = 0; e <= 7; e++) begin
      tick(1);
      if (e == 5) chk({tag, "_before"}, s1, 0);
      if (e == 6) begin
        chk({tag, "_sayi1"}, s1, 1);
        chk({tag, "_deg_hi"}, deg, 1);
      end
      if (e == 7) chk({tag, "_deg_lo"}, deg, 0);
    end
  endtask

  initial begin
    vecs[0]  = '{"inc2_a",       0, 1, 0, 1, 1, 1};
    vecs[1]  = '{"inc2_b",       0, 1, 0, 1, 2, 1};
    vecs[2]  = '{"inc2_c",       0, 1, 0, 1, 3, 1};
    vecs[3]  = '{"inc2_wrap",    0, 1, 0, 1, 0, 1};
    vecs[4]  = '{"inc1_to2",     1, 0, 0, 2, 0, 1};
    vecs[5]  = '{"inc2_to1",     0, 1, 0, 2, 1, 1};
    vecs[6]  = '{"inc2_to2",     0, 1, 0, 2, 2, 1};
    vecs[7]  = '{"inc2_to3",     0, 1, 0, 2, 3, 1};
    vecs[8]  = '{"clr_inc1",     1, 0, 1, 0, 0, 1};
    vecs[9]  = '{"clr_again",    0, 0, 1, 0, 0, 0};
    vecs[10] = '{"inc_both",     1, 1, 0, 1, 1, 1};
    vecs[11] = '{"clr_both",     0, 0, 1, 0, 0, 1};
    vecs[12] = '{"clr_inc_zero", 1, 1, 1, 0, 0, 0};

    // Reset state
    tick(3);
    chk("rst_sayi1", s1, 0);
    chk("rst_sayi2", s2, 0);
    chk("rst_deg", deg, 0);
    rst_n = 1'b1;
    tick(2);

    // Clean inc1 press: exact latency, then hold and release
    pulses = 0;
    b1 = 1'b1;
    latency_check("lat");
    tick(12);
    b1 = 1'b0;
    tick(20);
    chk("lat_hold_sayi1", s1, 1);
    chk("lat_hold_sayi2", s2, 0);
    chk("lat_pulses", pulses, 1);

    // Table of presses: each held 20 cycles, released 20 cycles
    for (int i = 0; i < 13; i++) begin
      pulses = 0;
      b1 = vecs[i].i1;
      b2 = vecs[i].i2;
      bc = vecs[i].c;
      tick(20);
      b1 = 1'b0;
      b2 = 1'b0;
      bc = 1'b0;
      tick(20);
      chk({vecs[i].nm, "_sayi1"}, s1, vecs[i].e1);
      chk({vecs[i].nm, "_sayi2"}, s2, vecs[i].e2);
      chk({vecs[i].nm, "_pulses"}, pulses, vecs[i].ep);
    end

    // Bounce 1-0-1-0 at 2-cycle intervals then a solid hold: one step
    pulses = 0;
    b1 = 1'b1; tick(2);
    b1 = 1'b0; tick(2);
    b1 = 1'b1; tick(2);
    b1 = 1'b0; tick(2);
    b1 = 1'b1; tick(10);
    b1 = 1'b0; tick(20);
    chk("bounce_sayi1", s1, 1);
    chk("bounce_pulses", pulses, 1);

    // A 3-cycle glitch alone must be rejected
    pulses = 0;
    b1 = 1'b1; tick(3);
    b1 = 1'b0; tick(20);
    chk("glitch_sayi1", s1, 1);
    chk("glitch_pulses", pulses, 0);

    // Reset mid-debounce (counter at 2) with inc1 held through deassertion
    pulses = 0;
    b1 = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_sayi1", s1, 0);
    chk("midrst_sayi2", s2, 0);
    chk("midrst_deg", deg, 0);
    tick(3);
    chk("inrst_sayi1", s1, 0);
    rst_n = 1'b1;
    latency_check("postrst");
    tick(10);
    b1 = 1'b0;
    tick(20);
    chk("postrst_final", s1, 1);
    chk("postrst_pulses", pulses, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
